// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks a + b + cin LSB first, one bit per
// clock, behind a valid/ready input port and a valid/ready result port.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and a result is held until taken.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              bit_a, bit_b, s_bit, c_next, last_bit;

  // Operands shift right each RUN edge, so bit[cnt] always sits at index 0.
  assign bit_a    = a_q[0];
  assign bit_b    = b_q[0];
  assign s_bit    = bit_a ^ bit_b ^ carry_q;
  assign c_next   = (bit_a & bit_b) | ((bit_a ^ bit_b) & carry_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = s_bit;
        carry_d          = c_next;
        cnt_d            = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status outputs are gated by rst_n so nothing is advertised during reset.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = rst_n && (state_q == S_DONE);
  assign busy      = rst_n && (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule
